// File: rtl/gyro_pkg.sv
// Shared types for the gyro sample sequencer: axis select, FSM states, rate word
// and the 17-to-16-bit saturation helper.
package gyro_pkg;

  localparam int unsigned NumAxes = 3;

  typedef logic signed [15:0] rate_t;

  typedef enum logic [1:0] {
    AXIS_X = 2'd0,
    AXIS_Y = 2'd1,
    AXIS_Z = 2'd2
  } axis_e;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StNext,
    StUpdate
  } state_e;

  function automatic rate_t sat16(input logic signed [16:0] d);
    if (d > 17'sd32767) begin
      return 16'sh7fff;
    end else if (d < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return d[15:0];
    end
  endfunction

endpackage

// File: rtl/sat_sub16.sv
// Saturating signed subtract y = clamp(a - b) with a 17-bit intermediate.
module sat_sub16
  import gyro_pkg::*;
(
  input  rate_t a,
  input  rate_t b,
  output rate_t y
);

  logic signed [16:0] diff;

  always_comb begin
    diff = {a[15], a} - {b[15], b};
    y    = sat16(diff);
  end

endmodule

// File: rtl/gyro_sample_sequencer.sv
// Periodically reads X/Y/Z rates from the IMU reader, calibrates a per-axis bias
// over 2^CAL_LOG2 samples, then emits bias-corrected, saturated rate triples.
module gyro_sample_sequencer
  import gyro_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned CAL_LOG2      = 4,
  parameter int unsigned TIMEOUT       = 1000
) (
  input  logic        clk_100mhz,
  input  logic        rst_in,
  input  logic        recal_in,
  output logic        rd_req,
  output logic [1:0]  rd_addr,
  input  logic        rd_ready,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic [15:0] gx,
  output logic [15:0] gy,
  output logic [15:0] gz,
  output logic        sample_valid,
  output logic        calibrated,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int unsigned CntW       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned TmoW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned AccW       = 16 + CAL_LOG2;
  localparam int unsigned CalW       = CAL_LOG2 + 1;
  localparam int unsigned CalSamples = 1 << CAL_LOG2;

  logic [CntW-1:0]        tick_cnt_q;
  logic                   tick;
  state_e                 state_q;
  axis_e                  axis_q;
  logic [TmoW-1:0]        tmo_q;
  logic [CalW-1:0]        cal_cnt_q;
  // Set when recal lands mid-sequence so the in-flight triple is thrown away.
  logic                   skip_q;
  rate_t                  raw_q    [NumAxes];
  rate_t                  bias_q   [NumAxes];
  logic signed [AccW-1:0] acc_q    [NumAxes];
  logic signed [AccW-1:0] acc_sum  [NumAxes];
  rate_t                  bias_nxt [NumAxes];
  rate_t                  corr     [NumAxes];

  assign tick    = (tick_cnt_q == CntW'(SAMPLE_PERIOD - 1));
  assign rd_addr = axis_q;

  for (genvar i = 0; i < NumAxes; i++) begin : g_axis
    sat_sub16 u_sat (
      .a (raw_q[i]),
      .b (bias_q[i]),
      .y (corr[i])
    );
    assign acc_sum[i]  = acc_q[i] + AccW'(raw_q[i]);
    assign bias_nxt[i] = rate_t'(acc_sum[i] >>> CAL_LOG2);
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      tick_cnt_q   <= '0;
      state_q      <= StIdle;
      axis_q       <= AXIS_X;
      tmo_q        <= '0;
      cal_cnt_q    <= '0;
      skip_q       <= 1'b0;
      rd_req       <= 1'b0;
      sample_valid <= 1'b0;
      calibrated   <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      gx           <= '0;
      gy           <= '0;
      gz           <= '0;
      for (int i = 0; i < NumAxes; i++) begin
        raw_q[i]  <= '0;
        bias_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      tick_cnt_q   <= tick ? '0 : tick_cnt_q + CntW'(1);
      sample_valid <= 1'b0;
      if (tick && state_q != StIdle) begin
        overrun <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (tick) begin
            axis_q  <= AXIS_X;
            rd_req  <= 1'b1;
            skip_q  <= 1'b0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (rd_ready) begin
            rd_req  <= 1'b0;
            tmo_q   <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (rd_valid) begin
            raw_q[axis_q] <= rd_data;
            state_q       <= StNext;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StNext: begin
          if (axis_q != AXIS_Z) begin
            axis_q  <= axis_e'(axis_q + 2'd1);
            rd_req  <= 1'b1;
            state_q <= StReq;
          end else begin
            state_q <= StUpdate;
          end
        end
        StUpdate: begin
          state_q <= StIdle;
          if (!skip_q && !recal_in) begin
            if (calibrated) begin
              gx           <= corr[0];
              gy           <= corr[1];
              gz           <= corr[2];
              sample_valid <= 1'b1;
            end else if (cal_cnt_q == CalW'(CalSamples - 1)) begin
              for (int i = 0; i < NumAxes; i++) begin
                bias_q[i] <= bias_nxt[i];
                acc_q[i]  <= '0;
              end
              cal_cnt_q  <= '0;
              calibrated <= 1'b1;
            end else begin
              for (int i = 0; i < NumAxes; i++) begin
                acc_q[i] <= acc_sum[i];
              end
              cal_cnt_q <= cal_cnt_q + CalW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Recal overrides any calibration bookkeeping done above in the same cycle.
      if (recal_in) begin
        calibrated <= 1'b0;
        cal_cnt_q  <= '0;
        for (int i = 0; i < NumAxes; i++) begin
          acc_q[i] <= '0;
        end
        if (state_q != StIdle && state_q != StUpdate) begin
          skip_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gyro_sample_sequencer.sv
// Directed + randomized bench for gyro_sample_sequencer against an integer model
// of calibration (floor-average bias) and saturated bias correction.
module tb_gyro_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        recal_in = 1'b0;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        rd_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic [15:0] gx, gy, gz;
  logic        sample_valid, calibrated, timeout_err, overrun;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_cal = 0;
  int m_n = 0;
  int m_sum[3];
  int m_bias[3];
  int m_g[3];

  always #5 clk = ~clk;

  gyro_sample_sequencer #(
    .SAMPLE_PERIOD (50),
    .CAL_LOG2      (2),
    .TIMEOUT       (1000)
  ) dut (
    .clk_100mhz   (clk),
    .rst_in       (rst_in),
    .recal_in     (recal_in),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .gx           (gx),
    .gy           (gy),
    .gz           (gz),
    .sample_valid (sample_valid),
    .calibrated   (calibrated),
    .timeout_err  (timeout_err),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  task automatic model_recal();
    m_cal = 0;
    m_n   = 0;
    for (int i = 0; i < 3; i++) m_sum[i] = 0;
  endtask

  // Returns whether a sample_valid pulse is expected for this triple.
  task automatic model_sample(input int x, input int y, input int z, output bit valid);
    int r[3];
    r[0] = x; r[1] = y; r[2] = z;
    valid = m_cal;
    if (m_cal) begin
      for (int i = 0; i < 3; i++) m_g[i] = clamp16(r[i] - m_bias[i]);
    end else begin
      for (int i = 0; i < 3; i++) m_sum[i] += r[i];
      m_n++;
      if (m_n == 4) begin
        for (int i = 0; i < 3; i++) begin
          m_bias[i] = floor_div4(m_sum[i]);
          m_sum[i]  = 0;
        end
        m_n   = 0;
        m_cal = 1;
      end
    end
  endtask

  // Starts and ends on a falling edge.
  task automatic wait_req(input string tag);
    int n = 0;
    while (rd_req !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rd_req !== 1'b1) chk({tag, "_req_seen"}, 0, 1);
  endtask

  task automatic serve_axis(input int axis, input logic [15:0] data, input int delay);
    bit stable = 1;
    wait_req("serve");
    chk("rd_addr", int'(rd_addr), axis);
    repeat (delay) begin
      @(negedge clk);
      if (rd_req !== 1'b1 || rd_addr !== 2'(axis)) stable = 0;
    end
    if (delay > 0) chk("rd_hold_stable", int'(stable), 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    rd_valid = 1'b1;
    rd_data  = data;
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (sample_valid === 1'b1) pulses++;
    end
  endtask

  task automatic run_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input int delay_x);
    bit exp_v;
    int pulses;
    model_sample(s16(x), s16(y), s16(z), exp_v);
    serve_axis(0, x, delay_x);
    serve_axis(1, y, 0);
    serve_axis(2, z, 0);
    count_pulses(6, pulses);
    chk("sample_valid_count", pulses, exp_v ? 1 : 0);
    if (exp_v) begin
      chk("gx", s16(gx), m_g[0]);
      chk("gy", s16(gy), m_g[1]);
      chk("gz", s16(gz), m_g[2]);
    end
    chk("calibrated", int'(calibrated), int'(m_cal));
  endtask

  initial begin
    int pulses;
    int n;
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0; m_bias[i] = 0; m_g[i] = 0;
    end

    repeat (3) @(negedge clk);
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_calibrated", int'(calibrated), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_gx", s16(gx), 0);
    chk("rst_gy", s16(gy), 0);
    chk("rst_gz", s16(gz), 0);
    rst_in = 1'b0;

    // Calibration: bias becomes (256, -128, 0)
    repeat (4) run_sample(16'd256, 16'hff80, 16'd0, 0);

    run_sample(16'd512, 16'hff80, 16'd46080, 0);
    chk("gx_const", s16(gx), 256);
    chk("gy_const", s16(gy), 0);
    chk("gz_const", s16(gz), -19456);

    for (int k = 0; k < 3; k++) begin
      run_sample(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 16'($urandom_range(0, 65535)), 0);
    end

    run_sample(16'h8000, 16'h7fff, 16'h8000, 0);
    chk("gx_sat_neg", s16(gx), -32768);

    // Backpressure for 60 cycles spans a tick -> overrun
    chk("overrun_before", int'(overrun), 0);
    run_sample(16'($urandom_range(0, 65535)), 16'd100, 16'd200, 60);
    chk("overrun_after", int'(overrun), 1);

    // Timeout on Y
    serve_axis(0, 16'd1, 0);
    wait_req("tmo");
    chk("tmo_addr", int'(rd_addr), 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    n = 0;
    pulses = 0;
    while (timeout_err !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
      if (sample_valid === 1'b1) pulses++;
    end
    chk("timeout_err", int'(timeout_err), 1);
    chk("timeout_cycles_ok", int'(n >= 999 && n <= 1001), 1);
    chk("timeout_no_valid", pulses, 0);
    run_sample(16'd300, 16'd0, 16'hfff0, 0);

    // Recal during axis Y: in-flight triple discarded, g* hold
    serve_axis(0, 16'd999, 0);
    recal_in = 1'b1;
    @(negedge clk);
    recal_in = 1'b0;
    model_recal();
    chk("recal_calibrated", int'(calibrated), 0);
    serve_axis(1, 16'd5, 0);
    serve_axis(2, 16'd7, 0);
    count_pulses(6, pulses);
    chk("recal_no_valid", pulses, 0);
    chk("recal_gx_hold", s16(gx), m_g[0]);
    chk("recal_gy_hold", s16(gy), m_g[1]);
    chk("recal_gz_hold", s16(gz), m_g[2]);
    chk("recal_still_uncal", int'(calibrated), 0);

    // Recalibrate with bias X=-256, random Y/Z
    for (int k = 0; k < 4; k++) begin
      run_sample(16'hff00, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 0);
    end
    run_sample(16'h7fff, 16'd0, 16'd0, 0);
    chk("gx_sat_pos", s16(gx), 32767);

    // Reset while a request is pending; late rd_valid ignored
    wait_req("rst");
    rst_in = 1'b1;
    @(negedge clk);
    chk("rst_mid_rd_req", int'(rd_req), 0);
    rst_in   = 1'b0;
    rd_valid = 1'b1;
    rd_data  = 16'h1234;
    @(negedge clk);
    rd_valid = 1'b0;
    count_pulses(4, pulses);
    chk("rst_mid_no_valid", pulses, 0);
    chk("rst_mid_calibrated", int'(calibrated), 0);
    chk("rst_mid_gx", s16(gx), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gyro_sample_sequencer.md
GYRO_SAMPLE_SEQUENCER -- requirements
Module: gyro_sample_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 100000, clock cycles between sample ticks (1 kHz at 100 MHz).
REQ-002 SHALL have parameter CAL_LOG2, default 4, log2 of the number of bias-calibration samples (16).
REQ-003 SHALL have parameter TIMEOUT, default 1000, maximum cycles from read acceptance to rd_valid.
REQ-004 SHALL use one clock and a synchronous active-high reset, with ports as listed below.
REQ-005 SHALL have port clk_100mhz  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in  in  1  synchronous, active-high reset.
REQ-007 SHALL have port recal_in  in  1  single-cycle pulse that restarts bias calibration.
REQ-008 SHALL have port rd_req  out  1  IMU register read request.
REQ-009 SHALL have port rd_addr  out  2  axis select: 0=X, 1=Y, 2=Z.
REQ-010 SHALL have port rd_ready  in  1  reader accepts the request when rd_req&&rd_ready.
REQ-011 SHALL have port rd_valid  in  1  one-cycle strobe marking rd_data valid.
REQ-012 SHALL have port rd_data  in  16  signed raw rate in 8.8 fixed point.
REQ-013 SHALL have ports gx, gy, gz  out  16 each  signed bias-corrected rates for the integrator.
REQ-014 SHALL have port sample_valid  out  1  one-cycle pulse when gx/gy/gz update together.
REQ-015 SHALL have port calibrated  out  1  high once bias values are valid.
REQ-016 SHALL have port timeout_err  out  1  sticky read-timeout flag.
REQ-017 SHALL have port overrun  out  1  sticky flag for a tick that arrived while busy.

Function
REQ-018 Tick counter SHALL count 0..SAMPLE_PERIOD-1 and wrap, asserting a one-cycle tick at wrap.
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, NEXT, UPDATE, with axis index 0..2.
REQ-020 IDLE: on tick, SHALL clear the axis index and go to REQ.
REQ-021 REQ: SHALL hold rd_req=1 and rd_addr=axis until rd_ready, then go to WAIT with the timeout counter cleared; rd_addr SHALL be stable while rd_req is high.
REQ-022 WAIT: on rd_valid, SHALL capture rd_data into the axis raw register and go to NEXT; rd_valid outside WAIT SHALL be ignored.
REQ-023 WAIT: if TIMEOUT cycles elapse without rd_valid, SHALL set timeout_err, discard the partial sample, and return to IDLE with no sample_valid.
REQ-024 NEXT: SHALL go to REQ with axis+1 when axis<2, else to UPDATE.
REQ-025 UPDATE (calibrated=1): SHALL output g* = sat16(raw* - bias*), pulse sample_valid for one cycle, and return to IDLE.
REQ-026 Saturation SHALL clamp to [-32768, 32767]; the subtraction SHALL be computed at 17 bits.
REQ-027 UPDATE (calibrated=0): SHALL add raw* to 16+CAL_LOG2-bit signed accumulators and increment the calibration count with no sample_valid; on the 2^CAL_LOG2-th sample, bias* SHALL be set to acc>>>CAL_LOG2 (arithmetic shift), calibrated SHALL be set, and the accumulators cleared.
REQ-028 A tick in any state other than IDLE SHALL be dropped and SHALL set overrun.
REQ-029 recal_in SHALL clear calibrated, the accumulators, and the calibration count; a sequence in flight SHALL finish its bus handshake but SHALL NOT update g* or the accumulators; g* SHALL hold its last values.
REQ-030 When a tick and recal_in occur in the same cycle, recal SHALL take effect first and the tick SHALL start a calibration sample.
REQ-031 Latency SHALL be tick to sample_valid = 3 handshakes + 4 cycles minimum.

Reset
REQ-032 On rst_in, the FSM SHALL enter IDLE and the tick counter SHALL be cleared to 0.
REQ-033 On rst_in, rd_req, sample_valid, calibrated, timeout_err and overrun SHALL be 0.
REQ-034 On rst_in, g*, bias*, accumulators and calibration count SHALL be 0.
REQ-035 Reset mid-handshake SHALL drop rd_req the next cycle; any late rd_valid SHALL be ignored.

Structure
REQ-036 The axis enum (AXIS_X/Y/Z), the state enum, and the 16-bit rate type SHALL live in shared package gyro_pkg.
REQ-037 The saturating subtract SHALL be a sub-module sat_sub16 (combinational, 16-bit signed in, 16-bit out).

Verification
REQ-038 Bench SHALL use SAMPLE_PERIOD=50 and CAL_LOG2=2.
REQ-039 Calibration: 4 samples with X=256, Y=-128, Z=0 -> no sample_valid pulses, calibrated=1 after the 4th, bias = (256, -128, 0).
REQ-040 Normal sample: after REQ-039, X=512, Y=-128, Z=46080 -> one sample_valid with gx=256, gy=0, gz=46080-wrapped-to-signed minus 0, i.e. gz=-19456.
REQ-041 Saturation: bias X=256, raw X=-32768 -> gx=-32768; bias X=-256, raw X=32767 -> gx=32767.
REQ-042 Timeout: rd_ready=1, rd_valid withheld on Y -> timeout_err=1 after 1000 cycles, no sample_valid, next tick completes normally.
REQ-043 Overrun / backpressure: rd_ready held low for 60 cycles -> rd_req and rd_addr stable throughout, overrun=1, one sample_valid afterwards.
REQ-044 Recal mid-sequence: recal_in pulsed during axis Y -> calibrated=0, g* unchanged, the next 4 samples recalibrate.
